// File: rtl/rng_fill_ctrl_if.sv
// RNG write-request channel between the refill scheduler (master) and the RNG-backed RAM (slave).
// Handshake: master pulses we_rng_o for one cycle with addr_rng_o valid, holds addr_rng_o until the slave
// pulses ack_rng_i for one cycle; at most one request is ever outstanding.
interface rng_fill_ctrl_if;
    logic       we_rng_o;
    logic [8:0] addr_rng_o;
    logic       ack_rng_i;

    modport master (output we_rng_o, output addr_rng_o, input ack_rng_i);
    modport slave  (input we_rng_o, input addr_rng_o, output ack_rng_i);
endinterface

// File: rtl/rng_fill_ctrl.sv
// Ring-buffer refill scheduler: keeps a window of RAM words filled with random data, one request at a time,
// tracking fill level, oldest-word address, watermarks and a sticky handshake timeout.
module rng_fill_ctrl #(
    parameter int unsigned BASE    = 0,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LOW_WM  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         flush_i,
    input  logic                         consume_i,
    rng_fill_ctrl_if.master              rng,
    output logic [8:0]                   rd_addr_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         low_o,
    output logic                         busy_o,
    output logic                         timeout_o,
    output logic [1:0]                   dbg_state_o
);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] PTR_MAX   = PW'(DEPTH - 1);
    localparam logic [LW-1:0] CNT_MAX   = LW'(DEPTH);
    localparam logic [LW-1:0] LOW_THR   = LW'(LOW_WM);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    localparam logic [8:0]    BASE_ADDR = 9'(BASE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;
    logic          drop_q, drop_d;
    logic [8:0]    addr_q, addr_d;

    logic ack_done, to_done, consume_ok, fill_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        drop_d     = drop_q;

        // Ack wins over timeout when both land on the last WAIT cycle.
        ack_done   = (state_q == S_WAIT) && rng.ack_rng_i;
        to_done    = (state_q == S_WAIT) && !rng.ack_rng_i && (wait_cnt_q == WAIT_LAST);
        consume_ok = consume_i && (count_q != '0) && !flush_i;
        fill_ok    = ack_done && !drop_q;

        case (state_q)
            S_IDLE: begin
                if (en_i && (count_q != CNT_MAX) && !timeout_q && !flush_i) state_d = S_REQ;
            end
            S_REQ: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (ack_done || to_done) state_d = S_IDLE;
                else                     wait_cnt_d = wait_cnt_q + TW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            timeout_d = 1'b0;
            // An in-flight request still completes; its data must not land in the emptied ring.
            drop_d    = (state_q != S_IDLE) && !ack_done && !to_done;
        end else begin
            if (ack_done) drop_d = 1'b0;
            if (fill_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (to_done) begin
                timeout_d = 1'b1;
                drop_d    = 1'b0;
            end
            if (consume_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({fill_ok, consume_ok})
                2'b10:   count_d = count_q + LW'(1);
                2'b01:   count_d = count_q - LW'(1);
                default: count_d = count_q;
            endcase
        end

        addr_d = BASE_ADDR + 9'(wr_ptr_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            drop_q     <= 1'b0;
            addr_q     <= BASE_ADDR;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            drop_q     <= drop_d;
            addr_q     <= addr_d;
        end
    end

    assign rng.we_rng_o   = (state_q == S_REQ);
    assign rng.addr_rng_o = addr_q;
    assign rd_addr_o      = BASE_ADDR + 9'(rd_ptr_q);
    assign level_o        = count_q;
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == CNT_MAX);
    assign low_o          = (count_q < LOW_THR);
    assign busy_o         = (state_q != S_IDLE);
    assign timeout_o      = timeout_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_rng_fill_ctrl.sv
// Bench for rng_fill_ctrl: directed scenarios plus randomized traffic against a queue-based ring model.
module tb_rng_fill_ctrl;
    localparam int BASE    = 8;
    localparam int DEPTH   = 4;
    localparam int LOW_WM  = 2;
    localparam int TIMEOUT = 8;

    logic                       clk_i, rst_ni, en_i, flush_i, consume_i;
    logic [8:0]                 rd_addr_o;
    logic [$clog2(DEPTH+1)-1:0] level_o;
    logic                       empty_o, full_o, low_o, busy_o, timeout_o;
    logic [1:0]                 dbg_state_o;

    rng_fill_ctrl_if rif();

    rng_fill_ctrl #(.BASE(BASE), .DEPTH(DEPTH), .LOW_WM(LOW_WM), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i), .consume_i(consume_i),
        .rng(rif), .rd_addr_o(rd_addr_o), .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
        .low_o(low_o), .busy_o(busy_o), .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_viol = 0;
    bit we_prev = 1'b0;

    always @(negedge clk_i) begin
        if (rst_ni && rif.we_rng_o && we_prev) pulse_viol++;
        we_prev = rif.we_rng_o;
    end

    // reference model: ring contents as a queue of written addresses
    logic [8:0] ring_q[$];
    int m_wr, m_phase, m_wait;
    bit m_to, m_drop;

    function automatic void model_reset();
        ring_q.delete();
        m_wr = 0; m_phase = 0; m_wait = 0; m_to = 0; m_drop = 0;
    endfunction

    // phase: 0 = no request, 1 = request pulse cycle, 2 = awaiting ack
    function automatic void model_step(input bit en, input bit fl, input bit cons, input bit ack);
        int sz0 = ring_q.size();
        bit to0 = m_to;
        int ph0 = m_phase;
        bit fin_ack = (ph0 == 2) && ack;
        bit fin_to  = (ph0 == 2) && !ack && (m_wait + 1 == TIMEOUT);
        if (ph0 == 0)                m_phase = (en && sz0 < DEPTH && !to0 && !fl) ? 1 : 0;
        else if (ph0 == 1)           begin m_phase = 2; m_wait = 0; end
        else if (fin_ack || fin_to)  m_phase = 0;
        else                         m_wait++;
        if (fl) begin
            ring_q.delete();
            m_wr = 0; m_to = 0;
            m_drop = (ph0 != 0) && !fin_ack && !fin_to;
        end else begin
            if (fin_ack) begin
                if (!m_drop) begin
                    ring_q.push_back(9'(BASE + m_wr));
                    m_wr = (m_wr + 1) % DEPTH;
                end
                m_drop = 0;
            end
            if (fin_to) begin m_to = 1; m_drop = 0; end
            if (cons && sz0 > 0) ring_q.delete(0);
        end
    endfunction

    // driver tasks
    task automatic cyc(input bit en, input bit fl, input bit cons, input bit ack);
        en_i = en; flush_i = fl; consume_i = cons; rif.ack_rng_i = ack;
        @(posedge clk_i); #1;
        model_step(en, fl, cons, ack);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; en_i = 0; flush_i = 0; consume_i = 0; rif.ack_rng_i = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic do_req(input bit ack_it, input int dly, output bit seen, output logic [8:0] a);
        seen = 0; a = '0;
        for (int i = 0; i < 8 && !seen; i++) begin
            cyc(1, 0, 0, 0);
            if (rif.we_rng_o) begin seen = 1; a = rif.addr_rng_o; end
        end
        if (seen) begin
            cyc(0, 0, 0, 0);
            for (int i = 0; i < dly; i++) cyc(0, 0, 0, 0);
            if (ack_it) cyc(0, 0, 0, 1);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; en_i = 0; flush_i = 0; consume_i = 0; rif.ack_rng_i = 0;
        @(posedge clk_i); #1;
        n_tests++;
        if ({rif.we_rng_o, busy_o, empty_o, full_o, low_o, timeout_o} !== 6'b001010) begin
            n_fail++; $display("FAIL reset_flags: got %b want 001010",
                {rif.we_rng_o, busy_o, empty_o, full_o, low_o, timeout_o});
        end
        n_tests++;
        if (level_o !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level_o); end
        n_tests++;
        if (rif.addr_rng_o !== 9'(BASE)) begin n_fail++; $display("FAIL reset_addr: got %0d want %0d", rif.addr_rng_o, BASE); end
        n_tests++;
        if (rd_addr_o !== 9'(BASE)) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want %0d", rd_addr_o, BASE); end
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        int nreq = 0, nack = 0, since = -1;
        bit a;
        for (int c = 0; c < 40; c++) begin
            a = (since == 3);
            cyc(1, 0, 0, a);
            if (since >= 0) since++;
            if (a) begin
                since = -1; nack++;
                n_tests++;
                if (level_o !== 3'(nack)) begin n_fail++; $display("FAIL fill_level: got %0d want %0d", level_o, nack); end
            end
            if (rif.we_rng_o) begin
                n_tests++;
                if (rif.addr_rng_o !== 9'(BASE + nreq)) begin
                    n_fail++; $display("FAIL fill_addr: got %0d want %0d", rif.addr_rng_o, BASE + nreq);
                end
                nreq++; since = 0;
            end
        end
        n_tests++;
        if (nreq !== 4) begin n_fail++; $display("FAIL fill_req_count: got %0d want 4", nreq); end
        n_tests++;
        if (full_o !== 1'b1 || level_o !== 3'd4) begin
            n_fail++; $display("FAIL fill_full: got full=%b level=%0d want full=1 level=4", full_o, level_o);
        end
        n_tests++;
        if (pulse_viol !== 0) begin n_fail++; $display("FAIL fill_single_pulse: got %0d violations want 0", pulse_viol); end
    endtask

    task automatic test_wrap();
        bit s; logic [8:0] a;
        cyc(0, 0, 1, 0);
        n_tests++;
        if (rd_addr_o !== 9'd9 || level_o !== 3'd3) begin
            n_fail++; $display("FAIL wrap_consume1: got rd=%0d level=%0d want rd=9 level=3", rd_addr_o, level_o);
        end
        cyc(0, 0, 1, 0);
        n_tests++;
        if (rd_addr_o !== 9'd10 || level_o !== 3'd2) begin
            n_fail++; $display("FAIL wrap_consume2: got rd=%0d level=%0d want rd=10 level=2", rd_addr_o, level_o);
        end
        do_req(1, 1, s, a);
        n_tests++;
        if (!s || a !== 9'd8) begin n_fail++; $display("FAIL wrap_refill1: got seen=%0d addr=%0d want seen=1 addr=8", s, a); end
        do_req(1, 2, s, a);
        n_tests++;
        if (!s || a !== 9'd9 || level_o !== 3'd4) begin
            n_fail++; $display("FAIL wrap_refill2: got seen=%0d addr=%0d level=%0d want 1/9/4", s, a, level_o);
        end
    endtask

    task automatic test_ack_and_consume();
        bit s; logic [8:0] a;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        do_req(0, 0, s, a);
        n_tests++;
        if (!s || a !== 9'd10 || level_o !== 3'd2 || rd_addr_o !== 9'd8) begin
            n_fail++; $display("FAIL simul_setup: got seen=%0d addr=%0d level=%0d rd=%0d want 1/10/2/8", s, a, level_o, rd_addr_o);
        end
        cyc(0, 0, 1, 1);
        n_tests++;
        if (level_o !== 3'd2 || rd_addr_o !== 9'd9 || rif.addr_rng_o !== 9'd11 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL simul_ack_consume: got level=%0d rd=%0d addr=%0d busy=%b want 2/9/11/0",
                level_o, rd_addr_o, rif.addr_rng_o, busy_o);
        end
    endtask

    task automatic test_empty_spurious();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        n_tests++;
        if (level_o !== 3'd0 || rd_addr_o !== 9'd11 || rif.addr_rng_o !== 9'd11) begin
            n_fail++; $display("FAIL consume_empty: got level=%0d rd=%0d addr=%0d want 0/11/11", level_o, rd_addr_o, rif.addr_rng_o);
        end
        cyc(0, 0, 0, 1);
        n_tests++;
        if (level_o !== 3'd0 || rd_addr_o !== 9'd11 || rif.addr_rng_o !== 9'd11 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL spurious_ack: got level=%0d rd=%0d addr=%0d busy=%b want 0/11/11/0",
                level_o, rd_addr_o, rif.addr_rng_o, busy_o);
        end
    endtask

    task automatic test_timeout();
        bit s; logic [8:0] a;
        int we_cnt = 0;
        do_req(0, 0, s, a);
        n_tests++;
        if (!s || a !== 9'd11) begin n_fail++; $display("FAIL timeout_req: got seen=%0d addr=%0d want 1/11", s, a); end
        for (int i = 1; i <= TIMEOUT; i++) begin
            cyc(1, 0, 0, 0);
            if (i == TIMEOUT - 1) begin
                n_tests++;
                if (timeout_o !== 1'b0 || busy_o !== 1'b1) begin
                    n_fail++; $display("FAIL timeout_early: got to=%b busy=%b want 0/1", timeout_o, busy_o);
                end
            end
        end
        n_tests++;
        if (timeout_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL timeout_set: got to=%b busy=%b want 1/0", timeout_o, busy_o);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1, 0, 0, 0);
            if (rif.we_rng_o) we_cnt++;
        end
        n_tests++;
        if (we_cnt !== 0) begin n_fail++; $display("FAIL timeout_blocks: got %0d requests want 0", we_cnt); end
        cyc(1, 1, 0, 0);
        n_tests++;
        if (timeout_o !== 1'b0 || level_o !== 3'd0 || rif.addr_rng_o !== 9'(BASE) || rd_addr_o !== 9'(BASE)) begin
            n_fail++; $display("FAIL timeout_flush: got to=%b level=%0d addr=%0d rd=%0d want 0/0/8/8",
                timeout_o, level_o, rif.addr_rng_o, rd_addr_o);
        end
        do_req(1, 0, s, a);
        n_tests++;
        if (!s || a !== 9'(BASE) || level_o !== 3'd1) begin
            n_fail++; $display("FAIL timeout_resume: got seen=%0d addr=%0d level=%0d want 1/8/1", s, a, level_o);
        end
    endtask

    task automatic test_flush_wait_reset();
        bit s; logic [8:0] a;
        do_req(1, 0, s, a);
        do_req(1, 1, s, a);
        do_req(0, 0, s, a);
        n_tests++;
        if (!s || level_o !== 3'd3 || a !== 9'd11) begin
            n_fail++; $display("FAIL flush_setup: got seen=%0d level=%0d addr=%0d want 1/3/11", s, level_o, a);
        end
        cyc(0, 1, 0, 0);
        n_tests++;
        if (level_o !== 3'd0 || busy_o !== 1'b1 || rd_addr_o !== 9'(BASE)) begin
            n_fail++; $display("FAIL flush_in_wait: got level=%0d busy=%b rd=%0d want 0/1/8", level_o, busy_o, rd_addr_o);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        n_tests++;
        if (level_o !== 3'd0 || busy_o !== 1'b0 || rif.addr_rng_o !== 9'(BASE)) begin
            n_fail++; $display("FAIL flush_drop_ack: got level=%0d busy=%b addr=%0d want 0/0/8", level_o, busy_o, rif.addr_rng_o);
        end
        do_req(1, 0, s, a);
        n_tests++;
        if (!s || a !== 9'(BASE) || level_o !== 3'd1) begin
            n_fail++; $display("FAIL flush_next_req: got seen=%0d addr=%0d level=%0d want 1/8/1", s, a, level_o);
        end
        do_req(0, 0, s, a);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        #2 rst_ni = 1'b0;
        #1;
        n_tests++;
        if ({rif.we_rng_o, busy_o, empty_o, full_o, low_o, timeout_o} !== 6'b001010 ||
            level_o !== 3'd0 || rif.addr_rng_o !== 9'(BASE) || rd_addr_o !== 9'(BASE)) begin
            n_fail++; $display("FAIL async_reset: got flags=%b level=%0d addr=%0d rd=%0d want 001010/0/8/8",
                {rif.we_rng_o, busy_o, empty_o, full_o, low_o, timeout_o}, level_o, rif.addr_rng_o, rd_addr_o);
        end
        do_reset();
    endtask

    task automatic test_random();
        int dly = 0, prev;
        bit en, fl, cons, ack;
        int exp_lvl;
        logic [8:0] exp_rd, exp_addr;
        logic [5:0] exp_st, got_st;
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            en   = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 63) == 0);
            cons = ($urandom_range(0, 2) == 0);
            if (m_phase == 2) ack = (dly == 0);
            else              ack = ($urandom_range(0, 31) == 0);
            prev = m_phase;
            cyc(en, fl, cons, ack);
            if (prev == 1 && m_phase == 2) dly = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 5);
            else if (m_phase == 2)         dly--;
            exp_lvl  = ring_q.size();
            exp_addr = 9'(BASE + m_wr);
            exp_rd   = (exp_lvl != 0) ? ring_q[0] : exp_addr;
            exp_st   = {m_phase == 1, m_phase != 0, exp_lvl == 0, exp_lvl == DEPTH, exp_lvl < LOW_WM, m_to};
            got_st   = {rif.we_rng_o, busy_o, empty_o, full_o, low_o, timeout_o};
            n_tests++;
            if (level_o !== 3'(exp_lvl)) begin n_fail++; $display("FAIL rand_level c=%0d: got %0d want %0d", c, level_o, exp_lvl); end
            n_tests++;
            if (rd_addr_o !== exp_rd) begin n_fail++; $display("FAIL rand_rd_addr c=%0d: got %0d want %0d", c, rd_addr_o, exp_rd); end
            n_tests++;
            if (rif.addr_rng_o !== exp_addr) begin n_fail++; $display("FAIL rand_addr c=%0d: got %0d want %0d", c, rif.addr_rng_o, exp_addr); end
            n_tests++;
            if (got_st !== exp_st) begin n_fail++; $display("FAIL rand_flags c=%0d: got %b want %b", c, got_st, exp_st); end
        end
        n_tests++;
        if (pulse_viol !== 0) begin n_fail++; $display("FAIL rand_single_pulse: got %0d violations want 0", pulse_viol); end
    endtask

    initial begin
        rif.ack_rng_i = 1'b0;
        test_reset();
        test_fill();
        test_wrap();
        test_ack_and_consume();
        test_empty_spurious();
        test_timeout();
        test_flush_wait_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rng_fill_ctrl.md
# rng_fill_ctrl

Refill scheduler for the RNG-backed RAM. It treats a parameterised window of RAM words as a ring buffer, and keeps that window topped up by issuing one-at-a-time random-write requests on the `we_rng`/`addr_rng`/`ack_rng` interface. A downstream consumer reads words over its own Wishbone port and reports each consumed word, which frees the slot for refill. The block tracks the fill level, the oldest-valid-word address and the watermarks, and it detects a stalled RNG handshake.

## Interface

Parameters:
- `BASE`, default 0: first RAM word address of the ring window.
- `DEPTH`, default 64: window size in words; 2 ≤ DEPTH, BASE+DEPTH ≤ 512.
- `LOW_WM`, default 16: low-watermark threshold; LOW_WM ≤ DEPTH.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before the block declares a timeout; ≥ 1.

Ports:
- `clk_i`, in, 1: single clock; all logic is on its rising edge.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `en_i`, in, 1: refill enable.
- `flush_i`, in, 1: pulse; empties the ring and clears `timeout_o`.
- `consume_i`, in, 1: pulse; the consumer has read the word at `rd_addr_o`.
- `we_rng_o`, out, 1: one-cycle write-request pulse to the RAM.
- `addr_rng_o`, out, 9: target word address; held stable from request until ack.
- `ack_rng_i`, in, 1: one-cycle pulse; the random word has been written.
- `rd_addr_o`, out, 9: BASE + rd_ptr, the address of the oldest valid word.
- `level_o`, out, clog2(DEPTH+1): count of valid words.
- `empty_o`, out, 1: count == 0.
- `full_o`, out, 1: count == DEPTH.
- `low_o`, out, 1: count < LOW_WM.
- `busy_o`, out, 1: FSM is not in IDLE.
- `timeout_o`, out, 1: sticky handshake-timeout flag.

## Operation

State:
- `wr_ptr` and `rd_ptr` each run 0..DEPTH-1 and wrap to 0 after DEPTH-1.
- `count` runs 0..DEPTH.
- `addr_rng_o` = BASE + wr_ptr, registered.

FSM has three states: IDLE, REQ, WAIT.
- **IDLE → REQ** when `en_i` && !full && !`timeout_o` && !`flush_i`.
- **REQ**: `we_rng_o` = 1 for exactly one cycle, then → WAIT unconditionally. `we_rng_o` is never high for two consecutive cycles.
- **WAIT → IDLE on `ack_rng_i`**:
  - wr_ptr++ with wrap.
  - count++, unless a flush discard is pending (see Flush).
- **WAIT → IDLE on timeout**: when the wait counter reaches TIMEOUT with no ack, set `timeout_o`. The pointers do not advance. No further requests issue until `flush_i` or reset.
- `ack_rng_i` in IDLE or REQ is spurious and is ignored.

Consume:
- `consume_i` with count > 0: rd_ptr++ with wrap, count--.
- `consume_i` with count == 0: ignored, no state change.
- Ack and consume in the same cycle: both pointers advance and count is unchanged.

Flush (`flush_i`):
- Next edge: rd_ptr = wr_ptr = count = 0 and `timeout_o` = 0.
- Flush in REQ or WAIT: the FSM completes the outstanding handshake. Set a `drop` flag so the resulting ack neither increments count nor advances wr_ptr. Clear `drop` on that ack or on timeout.
- `consume_i` coincident with `flush_i` is ignored.

`en_i` deassertion only stops new requests; an outstanding request completes.

## Timing

- Reset values:
  - `we_rng_o` 0; `addr_rng_o` BASE; `rd_addr_o` BASE.
  - `level_o` 0; `empty_o` 1; `full_o` 0; `low_o` 1 (0 if LOW_WM = 0).
  - `busy_o` 0; `timeout_o` 0; FSM in IDLE.
- All outputs are registered or decoded from registers; there is no combinational path from input to output.
- Request issue: condition true in cycle N; REQ in N+1 (`we_rng_o` high); WAIT from N+2.
- Completion: `ack_rng_i` in cycle M; `level_o`/`addr_rng_o` update and FSM is in IDLE at M+1. A new REQ is possible at M+2.
- Consume: `level_o`/`rd_addr_o` update one cycle after the `consume_i` cycle.
- Timeout: the wait counter clears on WAIT entry. `timeout_o` rises on the edge ending the TIMEOUT-th WAIT cycle.
- Reset asserted mid-WAIT returns the block to reset values immediately. The RAM side is reset by the same domain.

## Test plan

1. **Fill to full.** DEPTH=4, BASE=8. Hold `en_i`=1; the bench acks 3 cycles after each `we_rng_o`.
   - Required: `addr_rng_o` = 8, 9, 10, 11 on successive requests; `level_o` 1→4.
   - Required: `full_o`=1 after the 4th ack and no 5th `we_rng_o`; `we_rng_o` is always a single-cycle pulse.
2. **Wrap and refill.** From full, pulse `consume_i` twice.
   - Required: `rd_addr_o` 8→9→10; `level_o` 4→2.
   - Required: the next two requests target 8 then 9.
3. **Simultaneous ack and consume.** At level 2:
   - Required: `level_o` stays 2; rd_ptr and wr_ptr both advance.
4. **Consume while empty and spurious ack.** Pulse `consume_i` at level 0; pulse `ack_rng_i` in IDLE.
   - Required: no change to `level_o`, `rd_addr_o` or `addr_rng_o`.
5. **Timeout.** TIMEOUT=8; never ack.
   - Required: `timeout_o`=1 after 8 WAIT cycles; FSM in IDLE; no new `we_rng_o` while `en_i`=1.
   - Then `flush_i`: `timeout_o`=0 and requests resume at BASE.
6. **Flush mid-WAIT, then reset.** Flush at level 3 during WAIT; the ack arrives after the flush.
   - Required: `level_o`=0 and stays 0 after the ack; the next request targets BASE.
   - Then drop `rst_ni` mid-WAIT: all outputs take their reset values asynchronously.
